fifo_write_arbiter: RTL
=======================

# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the interleaved byte FIFO between `NumRequesters` producers (e.g. the command decoder, status reporter and debug tap feeding the UART TX path). It tracks FIFO occupancy in bytes from issued writes and consumer `ack` pulses, because the FIFO has no full flag. It enforces a minimum idle gap between writes so the FIFO's delayed pointer update completes before the next write. Sits between the producers and `fifo_interleaved`, in the same clock domain.

## Interface
- `NumRequesters`, 4: number of producers, ≥2.
- `CapacityBytes`, `FifoCapacityBytes` (config_pkg): total bytes the FIFO holds (2 buffer + memory).
- `MinGapCycles`, 1: idle cycles forced after every FIFO write, ≥1.
- `clk_i`  in  1  clock; all logic rising-edge.
- `reset_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  [NumRequesters]  requester i has an entry pending.
- `req_data_i`  in  [NumRequesters][FifoEntryWidthBits]  entry, MSB-first bytes as the FIFO expects.
- `req_width_i`  in  [NumRequesters][FifoEntryWidthSize+1]  entry length in bytes.
- `req_ready_o`  out  [NumRequesters]  one-cycle consume pulse to requester i.
- `fifo_write_enable_o`  out  1  to FIFO `write_enable`.
- `fifo_write_data_o`  out  FifoEntryWidthBits  to FIFO `write_data`.
- `fifo_write_width_o`  out  FifoEntryWidthSize+1  to FIFO `write_width`.
- `fifo_ack_i`  in  1  same signal driven to FIFO `ack`; one byte consumed.
- `level_o`  out  $clog2(CapacityBytes+1)  bytes currently committed to the FIFO.
- `err_o`  out  [NumRequesters]  sticky: requester i presented an illegal width.

## Operation
- State machine `IDLE`, `GAP`.
- `IDLE`: a winner is chosen combinationally. At the clock edge, output registers load the winner's data and width. `fifo_write_enable_o` and `req_ready_o[winner]` go high for exactly the next cycle. Go to `GAP` with counter = `MinGapCycles`.
- `GAP`: no grants. Decrement the counter each cycle. Return to `IDLE` when it reaches 0.
- Head selection: the head is the first i with `req_valid_i[i]`, searching from `rr_ptr` upward mod N.
- Legal width: 1..2**FifoEntryWidthSize.
- Illegal head width: pulse `req_ready_o[head]` with no FIFO write, set `err_o[head]`, advance `rr_ptr`, go to `GAP`.
- Legal head width ≤ free bytes (`CapacityBytes - level`): grant the head and set `rr_ptr <= head+1 mod N`.
- Legal head width > free bytes: no grant and `rr_ptr` unchanged. This head-of-line hold prevents starvation of wide entries; lower-priority requesters are not bypassed.
- Level update: `level <= level + (write ? width : 0) - (fifo_ack_i && level>0 ? 1 : 0)`. A simultaneous write and ack applies both in the same cycle.
- `fifo_ack_i` with level 0 is ignored.
- Level never exceeds `CapacityBytes` (guaranteed by the free-space check).
- Requester contract: hold `valid`, `data` and `width` stable until `ready`. After `ready`, present the next entry or drop `valid` by the following edge. This is safe because `GAP` ≥1 cycle.
- Reset (asynchronous, mid-operation included):
  - state `IDLE`, `rr_ptr` 0, level 0.
  - all outputs 0, including `err_o`.
  - the FIFO's synchronous reset must be asserted in the same reset window, so the two occupancy views stay consistent.

## Timing
- Grant latency: `valid` sampled at edge t gives `fifo_write_enable_o`/`req_ready_o` high during cycle t→t+1.
- Peak throughput: one write per `1+MinGapCycles` cycles.
- `level_o` reflects a write one cycle after `fifo_write_enable_o` rises, and an ack one cycle after `fifo_ack_i`.
- `fifo_write_data_o`/`fifo_write_width_o` are registered and hold their last value when `fifo_write_enable_o` is 0.
- No combinational path from any input to any output.

## Structure
- `config_pkg`:
  - add `FifoCapacityBytes`.
  - add `ArbStateT` enum {`IDLE`,`GAP`}.
  - reuse `FifoEntryWidthBits` and `FifoEntryWidthSize`.
- Sub-module `rr_priority_select`: combinational find-first-set from a rotating pointer; outputs the head index and a valid flag. It is reusable for the RX side later.
- Arbiter core: FSM, gap counter, level counter and output registers, in the top module.

## Test plan
- N=4, Capacity 8. Req1 valid, width 3, data 0x00AABBCC → next cycle write_enable=1, width=3, ready[1]=1; level_o=3 one cycle later; no grant for 1 cycle after.
- All four valid, width 1, rr_ptr 0, held valid → grants in order 0,1,2,3,0 at cycles 1,3,5,7,9; level reaches 5.
- Level 6, head req2 width 4, req3 width 1 valid → no grant, rr_ptr stays 2. Then 2 acks → level 4; req2 granted; level 8.
- Req0 width 0 → ready[0] pulses, write_enable stays 0, err_o=4'b0001 sticky. Width 5 on req3 → err_o=4'b1001.
- Write width 2 in the same cycle as `fifo_ack_i` at level 3 → level 4. Ack at level 0 → level stays 0.
- Assert `reset_ni`=0 mid-`GAP` with level 5 → outputs and level 0 immediately. After release, req1 is granted first from rr_ptr 0.

Source files
------------

// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
// Module      : config_pkg
// Description : Shared configuration for the UART TX byte-FIFO path: entry
//               geometry, FIFO capacity and the write-arbiter state type.
// Revision    : 1.0 - initial release
// ============================================================================
package config_pkg;

   // Entry width is expressed as log2 of the maximum byte count per entry.
   localparam int FifoEntryWidthSize = 2;
   localparam int FifoEntryWidthBits = 8 * (2 ** FifoEntryWidthSize);

   // Two output buffer bytes in front of the backing memory.
   localparam int FifoBufferBytes   = 2;
   localparam int FifoMemoryBytes   = 6;
   localparam int FifoCapacityBytes = FifoBufferBytes + FifoMemoryBytes;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      GAP  = 1'b1
   } ArbStateT;

endpackage
`default_nettype wire

// File: rtl/rr_priority_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_select
// Description : Combinational find-first-set starting at a rotating pointer
//               and wrapping modulo the requester count. Reports the index of
//               the first set request and whether any request was set.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_select #(
   parameter int NumReq = 4,
   parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic [NumReq-1:0] valid,
   input  logic [IdxW-1:0]   ptr,
   output logic [IdxW-1:0]   head,
   output logic              found
);

   int              idx_full;
   logic [IdxW-1:0] idx;

   // Walk upward from the pointer; the first pending request wins.
   always_comb begin
      head     = '0;
      found    = 1'b0;
      idx_full = 0;
      idx      = '0;
      for (int k = 0; k < NumReq; k++) begin
         idx_full = (int'(ptr) + k) % NumReq;
         idx      = idx_full[IdxW-1:0];
         if (!found && valid[idx]) begin
            found = 1'b1;
            head  = idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin arbiter sharing the FIFO write port between
//               several producers. Tracks committed bytes (the FIFO has no
//               full flag), holds the head-of-line entry until it fits, flags
//               illegal widths and forces idle gaps after every write.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter
   import config_pkg::*;
#(
   parameter int NumRequesters = 4,
   parameter int CapacityBytes = FifoCapacityBytes,
   parameter int MinGapCycles  = 1
) (
   input  logic                                               clk_i,
   input  logic                                               reset_ni,
   input  logic [NumRequesters-1:0]                           req_valid_i,
   input  logic [NumRequesters-1:0][FifoEntryWidthBits-1:0]   req_data_i,
   input  logic [NumRequesters-1:0][FifoEntryWidthSize:0]     req_width_i,
   output logic [NumRequesters-1:0]                           req_ready_o,
   output logic                                               fifo_write_enable_o,
   output logic [FifoEntryWidthBits-1:0]                      fifo_write_data_o,
   output logic [FifoEntryWidthSize:0]                        fifo_write_width_o,
   input  logic                                               fifo_ack_i,
   output logic [$clog2(CapacityBytes+1)-1:0]                 level_o,
   output logic [NumRequesters-1:0]                           err_o
);

   localparam int IdxW   = $clog2(NumRequesters);
   localparam int LevelW = $clog2(CapacityBytes + 1);
   localparam int GapW   = $clog2(MinGapCycles + 1);
   localparam int WidthW = FifoEntryWidthSize + 1;

   localparam logic [WidthW-1:0]        MaxWidth = WidthW'(2 ** FifoEntryWidthSize);
   localparam logic [IdxW-1:0]          LastIdx  = IdxW'(NumRequesters - 1);
   localparam logic [LevelW-1:0]        CapLevel = LevelW'(CapacityBytes);
   localparam logic [GapW-1:0]          GapLoad  = GapW'(MinGapCycles);

   ArbStateT                 state;
   logic [GapW-1:0]          gap_cnt;
   logic [IdxW-1:0]          rr_ptr;
   logic [IdxW-1:0]          head;
   logic                     head_found;
   logic [IdxW-1:0]          next_ptr;
   logic [NumRequesters-1:0] head_onehot;
   logic [WidthW-1:0]        head_width;
   logic                     head_legal;
   logic                     head_fits;
   logic [LevelW-1:0]        free_bytes;
   logic                     decide;
   logic                     grant;
   logic                     reject;
   logic [LevelW-1:0]        level_add;
   logic [LevelW-1:0]        level_sub;

   rr_priority_select #(
      .NumReq (NumRequesters),
      .IdxW   (IdxW)
   ) u_select (
      .valid (req_valid_i),
      .ptr   (rr_ptr),
      .head  (head),
      .found (head_found)
   );

   assign head_width  = req_width_i[head];
   assign head_onehot = NumRequesters'(1) << head;
   assign next_ptr    = (head == LastIdx) ? '0 : head + 1'b1;
   assign head_legal  = (head_width != '0) && (head_width <= MaxWidth);
   // Level never exceeds capacity, so the subtraction cannot wrap.
   assign free_bytes  = CapLevel - level_o;
   assign head_fits   = 32'(head_width) <= 32'(free_bytes);

   // An oversized legal head simply waits: nothing behind it may overtake.
   assign decide = (state == IDLE) && head_found;
   assign grant  = decide && head_legal && head_fits;
   assign reject = decide && !head_legal;

   // Writes land in the level one cycle after the enable pulse; acks on empty are dropped.
   always_comb begin
      level_add = '0;
      if (fifo_write_enable_o) begin
         level_add = LevelW'(fifo_write_width_o);
      end
   end
   assign level_sub = (fifo_ack_i && (level_o != '0)) ? LevelW'(1) : '0;

   // Arbitration FSM: a grant or reject starts a gap, the pointer moves past the served head.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state   <= IDLE;
         gap_cnt <= '0;
         rr_ptr  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant || reject) begin
                  state   <= GAP;
                  gap_cnt <= GapLoad;
                  rr_ptr  <= next_ptr;
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt - 1'b1;
               if (gap_cnt == GapW'(1)) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   // Registered write port and one-cycle consume pulses; data/width hold between writes.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         fifo_write_enable_o <= 1'b0;
         fifo_write_data_o   <= '0;
         fifo_write_width_o  <= '0;
         req_ready_o         <= '0;
      end else begin
         fifo_write_enable_o <= grant;
         req_ready_o         <= (grant || reject) ? head_onehot : '0;
         if (grant) begin
            fifo_write_data_o  <= req_data_i[head];
            fifo_write_width_o <= head_width;
         end
      end
   end

   // Sticky per-requester illegal-width flags.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         err_o <= '0;
      end else if (reject) begin
         err_o <= err_o | head_onehot;
      end
   end

   // Committed-byte occupancy; a write and an ack in the same cycle both apply.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         level_o <= '0;
      end else begin
         level_o <= level_o + level_add - level_sub;
      end
   end

endmodule
`default_nettype wire
